m_dmem_responder: RTL and testbench

Data-memory responder for the multi-cycle processor variant: the target end of the processor's load/store port. Accepts one request at a time over a valid/ready handshake, inserts a fixed number of wait states, performs a byte-strobed word write or a word read on an internal word array, then holds a response until it is accepted. Misaligned and out-of-range accesses are flagged with an error response and have no side effects.

---
 rtl/m_dmem_responder.sv | 144 ++++++++++++++
 tb/tb_m_dmem_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_dmem_responder.sv
// m_dmem_responder: data-memory target for the multi-cycle processor's load/store port.
// Accepts one request at a time, waits WAIT cycles, performs a byte-strobed
// word store or a word load on an internal array, then holds the response
// until the requester accepts it. Misaligned or out-of-range accesses return
// err=1 and leave the array untouched.
//
// Ports:
//   w_clk        clock, rising edge
//   w_rst_n      synchronous active-low reset
//   w_req_valid  request present            w_req_ready  responder can accept
//   w_req_we     1 = store, 0 = load        w_req_addr   byte address
//   w_req_wdata  store data                 w_req_wstrb  store byte enables
//   w_rsp_valid  response present           w_rsp_ready  requester accepts response
//   w_rsp_rdata  load data (0 for stores and errors)
//   w_rsp_err    misaligned or out-of-range access
module m_dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned WAIT       = 2
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        w_req_valid,
    output logic        w_req_ready,
    input  logic        w_req_we,
    input  logic [31:0] w_req_addr,
    input  logic [31:0] w_req_wdata,
    input  logic [3:0]  w_req_wstrb,
    output logic        w_rsp_valid,
    input  logic        w_rsp_ready,
    output logic [31:0] w_rsp_rdata,
    output logic        w_rsp_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               lat_we_q;
    logic [31:0]        lat_addr_q;
    logic [31:0]        lat_wdata_q;
    logic [3:0]         lat_wstrb_q;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic [31:0]        mem [DEPTH];

    logic               accept_c;
    logic               access_c;
    logic               rsp_done_c;
    logic               acc_err_c;
    logic [IDX_W-1:0]   idx_c;

    assign accept_c   = (state_q == ST_IDLE) && w_req_valid;
    assign access_c   = (state_q == ST_BUSY) && (cnt_q == '0);
    assign rsp_done_c = (state_q == ST_RESP) && w_rsp_ready;

    // Word index beyond the array or a non-word-aligned byte address is an error.
    assign acc_err_c  = (lat_addr_q[1:0] != 2'b00) || (lat_addr_q[31:2] >= 30'(DEPTH));
    assign idx_c      = lat_addr_q[IDX_W+1:2];

    // State register.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c)   state_d = ST_BUSY;
            ST_BUSY: if (access_c)   state_d = ST_RESP;
            ST_RESP: if (rsp_done_c) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: w_req_ready = 1'b1;
            ST_RESP: w_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Request latch and wait counter.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            cnt_q       <= '0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_wstrb_q <= '0;
        end else if (accept_c) begin
            cnt_q       <= CNT_W'(WAIT);
            lat_we_q    <= w_req_we;
            lat_addr_q  <= w_req_addr;
            lat_wdata_q <= w_req_wdata;
            lat_wstrb_q <= w_req_wstrb;
        end else if ((state_q == ST_BUSY) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Response registers; held through RESP until the handshake.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (access_c) begin
            err_q   <= acc_err_c;
            rdata_q <= (lat_we_q || acc_err_c) ? 32'h0 : mem[idx_c];
        end
    end

    assign w_rsp_rdata = rdata_q;
    assign w_rsp_err   = err_q;

    // Word array: not reset; a reset on the access edge suppresses the write.
    always_ff @(posedge w_clk) begin
        if (w_rst_n && access_c && lat_we_q && !acc_err_c) begin
            for (int k = 0; k < 4; k++) begin
                if (lat_wstrb_q[k]) begin
                    mem[idx_c][8*k +: 8] <= lat_wdata_q[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_m_dmem_responder.sv
module tb_m_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0: WAIT=2 instance, index 1: WAIT=0 instance.
    logic [1:0]        rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_we;
    logic [1:0][31:0]  req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0][3:0]   req_wstrb;
    logic [1:0]        rsp_ready;

    wire        ready0, ready1, valid0, valid1, err0, err1;
    wire [31:0] rdata0, rdata1;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [2][64];

    m_dmem_responder #(.DEPTH_LOG2(6), .WAIT(2)) u_dut0 (
        .w_clk       (clk),
        .w_rst_n     (rst_n[0]),
        .w_req_valid (req_valid[0]),
        .w_req_ready (ready0),
        .w_req_we    (req_we[0]),
        .w_req_addr  (req_addr[0]),
        .w_req_wdata (req_wdata[0]),
        .w_req_wstrb (req_wstrb[0]),
        .w_rsp_valid (valid0),
        .w_rsp_ready (rsp_ready[0]),
        .w_rsp_rdata (rdata0),
        .w_rsp_err   (err0)
    );

    m_dmem_responder #(.DEPTH_LOG2(6), .WAIT(0)) u_dut1 (
        .w_clk       (clk),
        .w_rst_n     (rst_n[1]),
        .w_req_valid (req_valid[1]),
        .w_req_ready (ready1),
        .w_req_we    (req_we[1]),
        .w_req_addr  (req_addr[1]),
        .w_req_wdata (req_wdata[1]),
        .w_req_wstrb (req_wstrb[1]),
        .w_rsp_valid (valid1),
        .w_rsp_ready (rsp_ready[1]),
        .w_rsp_rdata (rdata1),
        .w_rsp_err   (err1)
    );

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction
    function automatic logic o_ready(input int d);
        return (d == 0) ? ready0 : ready1;
    endfunction
    function automatic logic o_valid(input int d);
        return (d == 0) ? valid0 : valid1;
    endfunction
    function automatic logic o_err(input int d);
        return (d == 0) ? err0 : err1;
    endfunction
    function automatic logic [31:0] o_rdata(input int d);
        return (d == 0) ? rdata0 : rdata1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction with checks against the reference model.
    task automatic txn(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input int hold, input bit early,
                       output logic [31:0] got_rdata, output logic got_err);
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] held_rdata;
        logic        held_err;
        int          idx;
        int          lat;
        exp_err   = ((addr % 32'd4) != 32'd0) || ((addr / 32'd4) >= 32'd64);
        idx       = exp_err ? 0 : int'(addr / 32'd4);
        exp_rdata = (we || exp_err) ? 32'h0 : model[d][idx];

        chk("idle_ready", 32'(o_ready(d)), 32'd1);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_wstrb[d] = strb;
        rsp_ready[d] = early;
        tick();
        // Scramble request inputs after acceptance; the latched copy must be used.
        req_valid[d] = 1'b0;
        req_we[d]    = ~we;
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        req_wstrb[d] = 4'($urandom);

        lat = 0;
        while (!o_valid(d) && lat < 40) begin
            chk("busy_ready", 32'(o_ready(d)), 32'd0);
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'(wait_of(d) + 1));
        chk("rsp_err", 32'(o_err(d)), 32'(exp_err));
        chk("rsp_rdata", o_rdata(d), exp_rdata);
        chk("resp_ready", 32'(o_ready(d)), 32'd0);
        got_rdata  = o_rdata(d);
        got_err    = o_err(d);
        held_rdata = got_rdata;
        held_err   = got_err;

        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                tick();
                chk("hold_valid", 32'(o_valid(d)), 32'd1);
                chk("hold_rdata", o_rdata(d), held_rdata);
                chk("hold_err", 32'(o_err(d)), 32'(held_err));
                chk("hold_ready", 32'(o_ready(d)), 32'd0);
            end
            rsp_ready[d] = 1'b1;
        end
        tick();
        rsp_ready[d] = 1'b0;
        chk("done_valid", 32'(o_valid(d)), 32'd0);
        chk("done_ready", 32'(o_ready(d)), 32'd1);

        if (we && !exp_err) begin
            for (int k = 0; k < 4; k++) begin
                if (strb[k]) model[d][idx][8*k +: 8] = wdata[8*k +: 8];
            end
        end
    endtask

    // Accept a store to 0x30, then reset after 'pre' further edges.
    task automatic rst_mid(input int d, input int pre);
        req_valid[d] = 1'b1;
        req_we[d]    = 1'b1;
        req_addr[d]  = 32'h30;
        req_wdata[d] = 32'h55;
        req_wstrb[d] = 4'hF;
        tick();
        req_valid[d] = 1'b0;
        for (int i = 0; i < pre; i++) tick();
        chk("midrst_busy", 32'(o_valid(d)), 32'd0);
        rst_n[d] = 1'b0;
        tick();
        rst_n[d] = 1'b1;
        chk("midrst_ready", 32'(o_ready(d)), 32'd1);
        chk("midrst_valid", 32'(o_valid(d)), 32'd0);
        chk("midrst_rdata", o_rdata(d), 32'h0);
        chk("midrst_err", 32'(o_err(d)), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("midrst_norsp", 32'(o_valid(d)), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        e;
        logic [31:0] a;
        int          sel;

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 64; w++) model[d][w] = 32'h0;

        rst_n     = 2'b00;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = '0;
        tick();
        tick();
        rst_n = 2'b11;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(o_ready(d)), 32'd1);
            chk("rst_valid", 32'(o_valid(d)), 32'd0);
            chk("rst_rdata", o_rdata(d), 32'h0);
            chk("rst_err", 32'(o_err(d)), 32'd0);
        end

        // Bring the arrays to a known zero state.
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 64; w++)
                txn(d, 1'b1, 32'(w * 4), 32'h0, 4'hF, 0, 1'b1, r, e);

        // Store then load.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, r, e);
        chk("st10_err", 32'(e), 32'd0);
        chk("st10_rdata", r, 32'h0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, r, e);
        chk("ld10", r, 32'hDEADBEEF);

        // Byte strobes.
        txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0, r, e);
        txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 1'b0, r, e);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, r, e);
        chk("ld20_strb", r, 32'h11BB33DD);
        txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, 1'b0, r, e);
        chk("strb0_err", 32'(e), 32'd0);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, r, e);
        chk("ld20_strb0", r, 32'h11BB33DD);

        // Errors.
        txn(0, 1'b0, 32'h12, 32'h0, 4'h0, 0, 1'b0, r, e);
        chk("misalign_err", 32'(e), 32'd1);
        chk("misalign_rdata", r, 32'h0);
        txn(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0, 1'b0, r, e);
        txn(0, 1'b1, 32'h100, 32'h12345678, 4'hF, 0, 1'b0, r, e);
        chk("oor_err", 32'(e), 32'd1);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, r, e);
        chk("ld00_after_oor", r, 32'h0BADF00D);

        // Backpressure and early-ready.
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b0, r, e);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b1, r, e);
        txn(1, 1'b1, 32'h44, 32'hA5A5_5A5A, 4'hF, 5, 1'b0, r, e);
        txn(1, 1'b0, 32'h44, 32'h0, 4'h0, 0, 1'b1, r, e);
        chk("ld44_w0", r, 32'hA5A55A5A);

        // Reset mid-transaction; the second case resets on the access edge.
        txn(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 0, 1'b0, r, e);
        rst_mid(0, 1);
        txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0, r, e);
        chk("ld30_after_rst", r, 32'hCAFEF00D);
        txn(1, 1'b1, 32'h30, 32'h600DCAFE, 4'hF, 0, 1'b0, r, e);
        rst_mid(1, 0);
        txn(1, 1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0, r, e);
        chk("ld30_after_rst_w0", r, 32'h600DCAFE);

        // Randomized traffic against the model.
        for (int n = 0; n < 120; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = $urandom & 32'h0000_00FC;
            else if (sel == 7) a = ($urandom & 32'h0000_00FC) | 32'($urandom_range(1, 3));
            else if (sel == 8) a = 32'h100 + ($urandom & 32'h0000_0FFC);
            else               a = $urandom;
            txn(n % 2, 1'($urandom), a, $urandom, 4'($urandom),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), r, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
